// File: rtl/pc_branch_ctrl_pkg.sv
// Shared opcode, condition-code and state definitions for the PC/branch controller.
package pc_branch_ctrl_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_br_cond.sv
// Combinational branch-condition evaluator: (ccc, N, Z, V) -> cond.
module pc_branch_ctrl_br_cond
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       N_Flag,
  input  logic       Z_Flag,
  input  logic       V_Flag,
  output logic       cond
);

  // Condition decode from the flag register
  always_comb begin
    cond = 1'b0;
    case (ccc)
      CC_NE:     cond = ~Z_Flag;
      CC_EQ:     cond = Z_Flag;
      CC_GT:     cond = ~Z_Flag & ~N_Flag;
      CC_LT:     cond = N_Flag;
      CC_GE:     cond = Z_Flag | (~Z_Flag & ~N_Flag);
      CC_LE:     cond = N_Flag | Z_Flag;
      CC_OV:     cond = V_Flag;
      CC_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter owner: sequential fetch, B/BR redirect with one squashed slot, HLT.
// Optional macro BR_STATS_EN adds saturating taken/not-taken branch counters.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [3:0]      opcode,
  input  logic [2:0]      ccc,
  input  logic [8:0]      imm9,
  input  logic [PC_W-1:0] br_target,
  input  logic            N_Flag,
  input  logic            Z_Flag,
  input  logic            V_Flag,
  output logic [PC_W-1:0] fetch_pc,
  output logic [PC_W-1:0] dec_pc,
  output logic [PC_W-1:0] pcs_value,
  output logic            squash,
  output logic            branch_taken,
  output logic            halted
`ifdef BR_STATS_EN
  ,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     not_taken_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

  state_t          r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_dec_pc;
  logic            r_squash;
  logic            r_branch_taken;
  logic            r_halted;

  logic            w_cond;
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_imm_off;
  logic [PC_W-1:0] w_b_target;
  logic [PC_W-1:0] w_br_target;
  logic            w_is_b;
  logic            w_is_br;
  logic            w_is_hlt;

  pc_branch_ctrl_br_cond u_br_cond (
    .ccc    (ccc),
    .N_Flag (N_Flag),
    .Z_Flag (Z_Flag),
    .V_Flag (V_Flag),
    .cond   (w_cond)
  );

  // imm9 is a word offset, so it is sign-extended and scaled to bytes
  assign w_imm_off   = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
  assign w_seq       = r_fetch_pc + PC_STEP;
  assign w_b_target  = r_dec_pc + PC_STEP + w_imm_off;
  assign w_br_target = {br_target[PC_W-1:1], 1'b0};
  assign w_is_b      = (opcode == OP_B);
  assign w_is_br     = (opcode == OP_BR);
  assign w_is_hlt    = (opcode == OP_HLT);

  // PC, decode PC and control-state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_FLUSH;
      r_fetch_pc     <= RESET_PC;
      r_dec_pc       <= RESET_PC;
      r_squash       <= 1'b1;
      r_branch_taken <= 1'b0;
      r_halted       <= 1'b0;
    end else if (stall) begin
      r_branch_taken <= 1'b0;
    end else begin
      r_branch_taken <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_is_b && w_cond) begin
            r_fetch_pc     <= w_b_target;
            r_branch_taken <= 1'b1;
            r_state        <= ST_FLUSH;
            r_squash       <= 1'b1;
          end else if (w_is_br && w_cond) begin
            r_fetch_pc     <= w_br_target;
            r_branch_taken <= 1'b1;
            r_state        <= ST_FLUSH;
            r_squash       <= 1'b1;
          end else if (w_is_hlt) begin
            r_state        <= ST_HALT;
            r_squash       <= 1'b1;
            r_halted       <= 1'b1;
          end else begin
            r_dec_pc       <= r_fetch_pc;
            r_fetch_pc     <= w_seq;
          end
        end
        // The wrong-path slot is discarded: its opcode never acts
        ST_FLUSH: begin
          r_dec_pc   <= r_fetch_pc;
          r_fetch_pc <= w_seq;
          r_state    <= ST_RUN;
          r_squash   <= 1'b0;
        end
        ST_HALT: begin
          r_squash <= 1'b1;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_FLUSH;
          r_squash <= 1'b1;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_pc     = r_fetch_pc;
  assign dec_pc       = r_dec_pc;
  assign pcs_value    = r_dec_pc + PC_STEP;
  assign squash       = r_squash;
  assign branch_taken = r_branch_taken;
  assign halted       = r_halted;

`ifdef BR_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_not_taken_cnt;
  logic        w_br_eval;

  assign w_br_eval = (r_state == ST_RUN) && !stall && (w_is_b || w_is_br);

  // Saturating branch outcome counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken_cnt     <= 16'h0000;
      r_not_taken_cnt <= 16'h0000;
    end else if (w_br_eval && w_cond) begin
      r_taken_cnt     <= sat_inc16(r_taken_cnt);
    end else if (w_br_eval) begin
      r_not_taken_cnt <= sat_inc16(r_not_taken_cnt);
    end else begin
      r_taken_cnt     <= r_taken_cnt;
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
`endif

endmodule
